// File: rtl/mips_multicycle_controller.sv
// Multicycle MIPS control FSM: sequences fetch/decode/execute/memory/writeback
// and drives the shared ALU/memory datapath, with memory-ready stalls.
//
// state    | meaning
// ---------+-----------------------------------------------
// FETCH    | read instruction at PC, PC <= PC + 4
// DECODE   | read registers, compute branch target
// MEMADR   | compute lw/sw effective address
// MEMRD    | load access, held until memory ready
// MEMWB    | write load data to rt
// MEMWR    | store access, held until memory ready
// EXECUTE  | R-type ALU operation
// ALUWB    | write R-type result to rd
// BEQ/BNE  | compare registers, conditional PC load
// ADDIEX   | register + immediate
// ADDIWB   | write addi result to rt
// JUMP     | PC <= jump target
module mips_multicycle_controller #(
   parameter int ALUCTRL_W     = 3,
   parameter bit HAS_BNE       = 1'b1,
   parameter bit MEM_HANDSHAKE = 1'b1
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [5:0]           op,
   input  logic [5:0]           funct,
   input  logic                 zero,
   input  logic                 mem_ready,
   output logic                 iord,
   output logic                 memwrite,
   output logic                 irwrite,
   output logic                 regdst,
   output logic                 memtoreg,
   output logic                 regwrite,
   output logic                 alusrca,
   output logic [1:0]           alusrcb,
   output logic [1:0]           pcsrc,
   output logic                 pcen,
   output logic [ALUCTRL_W-1:0] alucontrol,
   output logic                 illegal_op
);

   localparam logic [3:0] S_FETCH   = 4'd0;
   localparam logic [3:0] S_DECODE  = 4'd1;
   localparam logic [3:0] S_MEMADR  = 4'd2;
   localparam logic [3:0] S_MEMRD   = 4'd3;
   localparam logic [3:0] S_MEMWB   = 4'd4;
   localparam logic [3:0] S_MEMWR   = 4'd5;
   localparam logic [3:0] S_EXECUTE = 4'd6;
   localparam logic [3:0] S_ALUWB   = 4'd7;
   localparam logic [3:0] S_BEQ     = 4'd8;
   localparam logic [3:0] S_BNE     = 4'd9;
   localparam logic [3:0] S_ADDIEX  = 4'd10;
   localparam logic [3:0] S_ADDIWB  = 4'd11;
   localparam logic [3:0] S_JUMP    = 4'd12;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_BNE   = 6'b000101;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_J     = 6'b000010;

   localparam logic [2:0] ALU_AND = 3'b000;
   localparam logic [2:0] ALU_OR  = 3'b001;
   localparam logic [2:0] ALU_ADD = 3'b010;
   localparam logic [2:0] ALU_SUB = 3'b110;
   localparam logic [2:0] ALU_SLT = 3'b111;

   logic [3:0] state;
   logic [3:0] state_next;
   logic       rdy;
   logic       set_illegal;
   logic       funct_legal;
   logic [2:0] funct_alu;
   logic [2:0] alu3;

   assign rdy = MEM_HANDSHAKE ? mem_ready : 1'b1;

   always_comb begin
      funct_legal = 1'b1;
      funct_alu   = ALU_ADD;
      case (funct)
         6'b100000: funct_alu = ALU_ADD;
         6'b100010: funct_alu = ALU_SUB;
         6'b100100: funct_alu = ALU_AND;
         6'b100101: funct_alu = ALU_OR;
         6'b101010: funct_alu = ALU_SLT;
         default:   funct_legal = 1'b0;
      endcase
   end

   always_comb begin
      state_next  = S_FETCH;
      set_illegal = 1'b0;
      iord        = 1'b0;
      memwrite    = 1'b0;
      irwrite     = 1'b0;
      regdst      = 1'b0;
      memtoreg    = 1'b0;
      regwrite    = 1'b0;
      alusrca     = 1'b0;
      alusrcb     = 2'b00;
      pcsrc       = 2'b00;
      pcen        = 1'b0;
      alu3        = 3'b000;
      case (state)
         S_FETCH: begin
            alusrcb    = 2'b01;
            alu3       = ALU_ADD;
            irwrite    = rdy;
            pcen       = rdy;
            state_next = rdy ? S_DECODE : S_FETCH;
         end
         S_DECODE: begin
            alusrcb = 2'b11;
            alu3    = ALU_ADD;
            case (op)
               OP_LW, OP_SW: state_next = S_MEMADR;
               OP_RTYPE:     state_next = S_EXECUTE;
               OP_BEQ:       state_next = S_BEQ;
               OP_ADDI:      state_next = S_ADDIEX;
               OP_J:         state_next = S_JUMP;
               OP_BNE: begin
                  if (HAS_BNE) state_next = S_BNE;
                  else         set_illegal = 1'b1;
               end
               default:      set_illegal = 1'b1;
            endcase
         end
         S_MEMADR: begin
            alusrca    = 1'b1;
            alusrcb    = 2'b10;
            alu3       = ALU_ADD;
            state_next = (op == OP_LW) ? S_MEMRD : S_MEMWR;
         end
         S_MEMRD: begin
            iord       = 1'b1;
            state_next = rdy ? S_MEMWB : S_MEMRD;
         end
         S_MEMWB: begin
            memtoreg = 1'b1;
            regwrite = 1'b1;
         end
         S_MEMWR: begin
            iord       = 1'b1;
            memwrite   = 1'b1;
            state_next = rdy ? S_FETCH : S_MEMWR;
         end
         S_EXECUTE: begin
            alusrca = 1'b1;
            alu3    = funct_alu;
            if (funct_legal) state_next = S_ALUWB;
            else             set_illegal = 1'b1;
         end
         S_ALUWB: begin
            regdst   = 1'b1;
            regwrite = 1'b1;
         end
         S_BEQ, S_BNE: begin
            alusrca = 1'b1;
            alu3    = ALU_SUB;
            pcsrc   = 2'b01;
            pcen    = (state == S_BEQ) ? zero : ~zero;
         end
         S_ADDIEX: begin
            alusrca    = 1'b1;
            alusrcb    = 2'b10;
            alu3       = ALU_ADD;
            state_next = S_ADDIWB;
         end
         S_ADDIWB: regwrite = 1'b1;
         S_JUMP: begin
            pcsrc = 2'b10;
            pcen  = 1'b1;
         end
         default: state_next = S_FETCH;
      endcase
      // Strobes must never fire while reset is held, even combinationally.
      if (reset) begin
         irwrite  = 1'b0;
         pcen     = 1'b0;
         regwrite = 1'b0;
         memwrite = 1'b0;
      end
   end

   generate
      if (ALUCTRL_W > 3) begin : g_alu_wide
         assign alucontrol = {{(ALUCTRL_W-3){1'b0}}, alu3};
      end else begin : g_alu_narrow
         assign alucontrol = alu3[ALUCTRL_W-1:0];
      end
   endgenerate

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= S_FETCH;
         illegal_op <= 1'b0;
      end else begin
         state <= state_next;
         if (set_illegal) illegal_op <= 1'b1;
      end
   end

endmodule

// File: tb/tb_mips_multicycle_controller.sv
// Bench for mips_multicycle_controller: per-instruction phase sequences built
// from the instruction class and stall counts, checked every cycle.
module tb_mips_multicycle_controller;

   logic       clk = 1'b0;
   logic       reset;
   logic [5:0] op, funct;
   logic       zero, mem_ready;

   logic       iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca, pcen, illegal_op;
   logic [1:0] alusrcb, pcsrc;
   logic [2:0] alucontrol;

   logic       iord_nb, memwrite_nb, irwrite_nb, regdst_nb, memtoreg_nb, regwrite_nb, alusrca_nb, pcen_nb, illegal_op_nb;
   logic [1:0] alusrcb_nb, pcsrc_nb;
   logic [2:0] alucontrol_nb;

   mips_multicycle_controller dut (
      .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero), .mem_ready(mem_ready),
      .iord(iord), .memwrite(memwrite), .irwrite(irwrite), .regdst(regdst), .memtoreg(memtoreg),
      .regwrite(regwrite), .alusrca(alusrca), .alusrcb(alusrcb), .pcsrc(pcsrc), .pcen(pcen),
      .alucontrol(alucontrol), .illegal_op(illegal_op)
   );

   mips_multicycle_controller #(.HAS_BNE(1'b0)) dut_nb (
      .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero), .mem_ready(mem_ready),
      .iord(iord_nb), .memwrite(memwrite_nb), .irwrite(irwrite_nb), .regdst(regdst_nb),
      .memtoreg(memtoreg_nb), .regwrite(regwrite_nb), .alusrca(alusrca_nb), .alusrcb(alusrcb_nb),
      .pcsrc(pcsrc_nb), .pcen(pcen_nb), .alucontrol(alucontrol_nb), .illegal_op(illegal_op_nb)
   );

   always #5 clk = ~clk;

   typedef enum int {P_FETCH, P_DECODE, P_MEMADR, P_MEMRD, P_MEMWB, P_MEMWR,
                     P_EXEC, P_ALUWB, P_BR, P_ADDIEX, P_ADDIWB, P_JUMP} phase_t;
   typedef struct {
      phase_t ph;
      logic   rdy;
      logic   ill;
   } step_t;

   // {iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca, alusrcb, pcsrc, pcen, alucontrol, illegal_op}
   localparam logic [15:0] RST_VEC = {7'b0000000, 2'b01, 2'b00, 1'b0, 3'b010, 1'b0};

   logic [15:0] act_vec, act_nb;
   assign act_vec = {iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca,
                     alusrcb, pcsrc, pcen, alucontrol, illegal_op};
   assign act_nb  = {iord_nb, memwrite_nb, irwrite_nb, regdst_nb, memtoreg_nb, regwrite_nb,
                     alusrca_nb, alusrcb_nb, pcsrc_nb, pcen_nb, alucontrol_nb, illegal_op_nb};

   int          n_checks = 0;
   int          n_fail   = 0;
   logic        exp_valid = 1'b0;
   logic        nb_valid  = 1'b0;
   logic        pin_valid = 1'b0;
   logic [15:0] exp_vec, exp_nb, pin_vec;
   int          cur_instr = 0;
   int          cur_step  = 0;
   logic        model_ill = 1'b0;
   step_t       q[$];

   always @(negedge clk) begin
      if (exp_valid) begin
         n_checks++;
         if (act_vec !== exp_vec) begin
            n_fail++;
            $display("FAIL outputs instr %0d step %0d: got %b want %b", cur_instr, cur_step, act_vec, exp_vec);
         end
      end
      if (pin_valid) begin
         n_checks++;
         if (act_vec !== pin_vec) begin
            n_fail++;
            $display("FAIL pinned instr %0d step %0d: got %b want %b", cur_instr, cur_step, act_vec, pin_vec);
         end
      end
      if (nb_valid) begin
         n_checks++;
         if (act_nb !== exp_nb) begin
            n_fail++;
            $display("FAIL no_bne step %0d: got %b want %b", cur_step, act_nb, exp_nb);
         end
      end
   end

   function automatic logic funct_ok(input logic [5:0] f);
      return (f == 6'b100000) || (f == 6'b100010) || (f == 6'b100100) ||
             (f == 6'b100101) || (f == 6'b101010);
   endfunction

   function automatic logic [2:0] funct_alu(input logic [5:0] f);
      case (f)
         6'b100010: return 3'b110;
         6'b100100: return 3'b000;
         6'b100101: return 3'b001;
         6'b101010: return 3'b111;
         default:   return 3'b010;
      endcase
   endfunction

   // Output table per phase; anything not named for a phase stays 0.
   function automatic logic [15:0] expected(input step_t s, input logic [5:0] o,
                                            input logic [5:0] f, input logic z);
      logic e_iord, e_mw, e_ir, e_rd, e_m2r, e_rw, e_asa, e_pcen;
      logic [1:0] e_asb, e_pcs;
      logic [2:0] e_alu;
      {e_iord, e_mw, e_ir, e_rd, e_m2r, e_rw, e_asa, e_pcen} = 8'b0;
      e_asb = 2'b00;
      e_pcs = 2'b00;
      e_alu = 3'b000;
      case (s.ph)
         P_FETCH:  begin e_ir = s.rdy; e_pcen = s.rdy; e_asb = 2'b01; e_alu = 3'b010; end
         P_DECODE: begin e_asb = 2'b11; e_alu = 3'b010; end
         P_MEMADR: begin e_asa = 1'b1; e_asb = 2'b10; e_alu = 3'b010; end
         P_MEMRD:  e_iord = 1'b1;
         P_MEMWB:  begin e_m2r = 1'b1; e_rw = 1'b1; end
         P_MEMWR:  begin e_iord = 1'b1; e_mw = 1'b1; end
         P_EXEC:   begin e_asa = 1'b1; e_alu = funct_alu(f); end
         P_ALUWB:  begin e_rd = 1'b1; e_rw = 1'b1; end
         P_BR:     begin e_asa = 1'b1; e_alu = 3'b110; e_pcs = 2'b01;
                         e_pcen = (o == 6'b000101) ? ~z : z; end
         P_ADDIEX: begin e_asa = 1'b1; e_asb = 2'b10; e_alu = 3'b010; end
         P_ADDIWB: e_rw = 1'b1;
         P_JUMP:   begin e_pcs = 2'b10; e_pcen = 1'b1; end
         default:  e_alu = 3'b000;
      endcase
      return {e_iord, e_mw, e_ir, e_rd, e_m2r, e_rw, e_asa, e_asb, e_pcs, e_pcen, e_alu, s.ill};
   endfunction

   function automatic logic rnd_bit();
      return logic'($urandom_range(0, 1));
   endfunction

   function void add(input phase_t p, input logic r);
      step_t s;
      s.ph  = p;
      s.rdy = r;
      s.ill = model_ill;
      q.push_back(s);
   endfunction

   // Entered and left at posedge+1 with the DUT in FETCH.
   task automatic run_instr(input logic [5:0] o, input logic [5:0] f, input logic z,
                            input int fst, input int mst, input int abort_at,
                            input int pa_step, input logic [15:0] pa_vec,
                            input int pb_step, input logic [15:0] pb_vec);
      q.delete();
      for (int i = 0; i < fst; i++) add(P_FETCH, 1'b0);
      add(P_FETCH, 1'b1);
      add(P_DECODE, rnd_bit());
      case (o)
         6'b100011: begin
            add(P_MEMADR, rnd_bit());
            for (int i = 0; i < mst; i++) add(P_MEMRD, 1'b0);
            add(P_MEMRD, 1'b1);
            add(P_MEMWB, rnd_bit());
         end
         6'b101011: begin
            add(P_MEMADR, rnd_bit());
            for (int i = 0; i < mst; i++) add(P_MEMWR, 1'b0);
            add(P_MEMWR, 1'b1);
         end
         6'b000000: begin
            add(P_EXEC, rnd_bit());
            if (funct_ok(f)) add(P_ALUWB, rnd_bit());
            else model_ill = 1'b1;
         end
         6'b000100, 6'b000101: add(P_BR, rnd_bit());
         6'b001000: begin
            add(P_ADDIEX, rnd_bit());
            add(P_ADDIWB, rnd_bit());
         end
         6'b000010: add(P_JUMP, rnd_bit());
         default: model_ill = 1'b1;
      endcase
      for (int k = 0; k < q.size(); k++) begin
         op        = o;
         funct     = f;
         zero      = z;
         mem_ready = q[k].rdy;
         cur_step  = k;
         exp_vec   = expected(q[k], o, f, z);
         pin_valid = (k == pa_step) || (k == pb_step);
         pin_vec   = (k == pa_step) ? pa_vec : pb_vec;
         if (k == abort_at) begin
            #2;
            pin_valid = 1'b0;
            reset     = 1'b1;
            exp_vec   = RST_VEC;
            model_ill = 1'b0;
            @(posedge clk);
            #1;
            reset = 1'b0;
            cur_instr++;
            return;
         end
         @(posedge clk);
         #1;
      end
      pin_valid = 1'b0;
      cur_instr++;
   endtask

   logic [5:0] r_op, r_f;
   int         kind;
   step_t      st;

   initial begin
      reset     = 1'b1;
      op        = 6'b0;
      funct     = 6'b0;
      zero      = 1'b0;
      mem_ready = 1'b1;
      exp_vec   = RST_VEC;
      exp_valid = 1'b1;
      @(posedge clk);
      @(posedge clk);
      #1;
      reset = 1'b0;

      run_instr(6'b000000, 6'b100000, 1'b0, 0, 0, -1,
                2, {7'b0000001, 2'b00, 2'b00, 1'b0, 3'b010, 1'b0},
                3, {7'b0001010, 2'b00, 2'b00, 1'b0, 3'b000, 1'b0});
      run_instr(6'b000000, 6'b101010, 1'b1, 0, 0, -1,
                2, {7'b0000001, 2'b00, 2'b00, 1'b0, 3'b111, 1'b0}, -1, 16'h0);
      run_instr(6'b100011, 6'b000000, 1'b0, 0, 2, -1,
                3, {7'b1000000, 2'b00, 2'b00, 1'b0, 3'b000, 1'b0},
                6, {7'b0000110, 2'b00, 2'b00, 1'b0, 3'b000, 1'b0});
      run_instr(6'b000100, 6'b000000, 1'b1, 0, 0, -1,
                2, {7'b0000001, 2'b00, 2'b01, 1'b1, 3'b110, 1'b0}, -1, 16'h0);
      run_instr(6'b000100, 6'b000000, 1'b0, 0, 0, -1,
                2, {7'b0000001, 2'b00, 2'b01, 1'b0, 3'b110, 1'b0}, -1, 16'h0);
      run_instr(6'b000101, 6'b000000, 1'b0, 0, 0, -1,
                2, {7'b0000001, 2'b00, 2'b01, 1'b1, 3'b110, 1'b0}, -1, 16'h0);
      run_instr(6'b000101, 6'b000000, 1'b1, 0, 0, -1, -1, 16'h0, -1, 16'h0);
      run_instr(6'b101011, 6'b000000, 1'b0, 1, 0, -1,
                0, {7'b0000000, 2'b01, 2'b00, 1'b0, 3'b010, 1'b0},
                4, {7'b1100000, 2'b00, 2'b00, 1'b0, 3'b000, 1'b0});
      run_instr(6'b111111, 6'b000000, 1'b0, 0, 0, -1,
                1, {7'b0000000, 2'b11, 2'b00, 1'b0, 3'b010, 1'b0}, -1, 16'h0);
      run_instr(6'b000000, 6'b000000, 1'b0, 0, 0, -1,
                2, {7'b0000001, 2'b00, 2'b00, 1'b0, 3'b010, 1'b1}, -1, 16'h0);
      run_instr(6'b000010, 6'b000000, 1'b0, 0, 0, -1,
                2, {7'b0000000, 2'b00, 2'b10, 1'b1, 3'b000, 1'b1}, -1, 16'h0);
      // Reset pulse while regwrite is high in ALUWB; illegal_op is set beforehand.
      run_instr(6'b000000, 6'b100000, 1'b0, 0, 0, 3, -1, 16'h0, -1, 16'h0);

      for (int n = 0; n < 300; n++) begin
         kind = int'($urandom_range(0, 7));
         r_f  = 6'($urandom_range(0, 63));
         case (kind)
            0: r_op = 6'b100011;
            1: r_op = 6'b101011;
            2: begin
               r_op = 6'b000000;
               if ($urandom_range(0, 4) != 0) begin
                  case ($urandom_range(0, 4))
                     0: r_f = 6'b100000;
                     1: r_f = 6'b100010;
                     2: r_f = 6'b100100;
                     3: r_f = 6'b100101;
                     default: r_f = 6'b101010;
                  endcase
               end
            end
            3: r_op = 6'b000100;
            4: r_op = 6'b000101;
            5: r_op = 6'b001000;
            6: r_op = 6'b000010;
            default: begin
               r_op = 6'b111111;
               for (int t = 0; t < 64; t++) begin
                  r_op = 6'($urandom_range(0, 63));
                  if (!(r_op inside {6'b100011, 6'b101011, 6'b000000, 6'b000100,
                                     6'b000101, 6'b001000, 6'b000010})) break;
                  r_op = 6'b111111;
               end
            end
         endcase
         run_instr(r_op, r_f, rnd_bit(), int'($urandom_range(0, 2)), int'($urandom_range(0, 2)),
                   -1, -1, 16'h0, -1, 16'h0);
         if ($urandom_range(0, 49) == 0)
            run_instr(6'b000000, 6'b100101, 1'b0, 0, 0, 3, -1, 16'h0, -1, 16'h0);
      end

      // Same bne stream into both instances: the BNE-less one must flag it.
      reset     = 1'b1;
      op        = 6'b000101;
      funct     = 6'b000000;
      zero      = 1'b0;
      mem_ready = 1'b1;
      exp_vec   = RST_VEC;
      exp_nb    = RST_VEC;
      nb_valid  = 1'b1;
      model_ill = 1'b0;
      @(posedge clk);
      #1;
      reset = 1'b0;
      st.ill = 1'b0;
      st.rdy = 1'b1;
      st.ph = P_FETCH;
      cur_step = 0;
      exp_vec = expected(st, op, funct, zero);
      exp_nb  = {7'b0010000, 2'b01, 2'b00, 1'b1, 3'b010, 1'b0};
      @(posedge clk);
      #1;
      st.ph = P_DECODE;
      cur_step = 1;
      exp_vec = expected(st, op, funct, zero);
      exp_nb  = {7'b0000000, 2'b11, 2'b00, 1'b0, 3'b010, 1'b0};
      @(posedge clk);
      #1;
      st.ph = P_BR;
      cur_step = 2;
      exp_vec = expected(st, op, funct, zero);
      exp_nb  = {7'b0010000, 2'b01, 2'b00, 1'b1, 3'b010, 1'b1};
      @(negedge clk);
      #1;
      exp_valid = 1'b0;
      nb_valid  = 1'b0;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
